// File: rtl/frame_capture_writer.sv
// Snapshot writer: grabs one RGB444 frame, converts each pixel to 4-bit gray,
// and writes it in raster order into the frame-buffer BRAM write port.
module frame_capture_writer #(
    parameter int WIDTH_ADDR  = 16,
    parameter int WIDTH_COLOR = 4,
    parameter int WIDTH_IMG   = 200,
    parameter int HEIGHT_IMG  = 200
) (
    input  logic                     pixel_clk,
    input  logic                     rst_n,
    input  logic                     arm,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     s_sof,
    input  logic [3*WIDTH_COLOR-1:0] s_rgb,
    output logic                     wr_en,
    output logic [WIDTH_ADDR-1:0]    wr_addr,
    output logic [WIDTH_COLOR-1:0]   wr_data,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     err_sync
);

    localparam int unsigned            FRAME_PIXELS = WIDTH_IMG * HEIGHT_IMG;
    localparam logic [WIDTH_ADDR-1:0]  LAST_ADDR    = WIDTH_ADDR'(FRAME_PIXELS - 1);
    localparam int                     SUMW         = WIDTH_COLOR + 4;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_SOF = 2'd1;
    localparam logic [1:0] ST_CAPTURE  = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [WIDTH_ADDR-1:0]  cnt_q, cnt_d;
    logic                   s_ready_q, s_ready_d;
    logic                   wr_en_q, wr_en_d;
    logic [WIDTH_ADDR-1:0]  wr_addr_q, wr_addr_d;
    logic [WIDTH_COLOR-1:0] wr_data_q, wr_data_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    logic                   err_sync_q, err_sync_d;

    logic                   accept;
    logic [WIDTH_COLOR-1:0] ch_r, ch_g, ch_b;
    logic [SUMW-1:0]        gray_sum;
    logic [WIDTH_COLOR-1:0] gray;

    assign accept = s_valid & s_ready_q;
    assign ch_r   = s_rgb[3*WIDTH_COLOR-1:2*WIDTH_COLOR];
    assign ch_g   = s_rgb[2*WIDTH_COLOR-1:WIDTH_COLOR];
    assign ch_b   = s_rgb[WIDTH_COLOR-1:0];

    // Weights 5/9/2 sum to 16, so the top WIDTH_COLOR bits of the sum are the gray level.
    assign gray_sum = SUMW'(ch_r) * SUMW'(5) + SUMW'(ch_g) * SUMW'(9) + SUMW'(ch_b) * SUMW'(2);
    assign gray     = gray_sum[SUMW-1:4];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        s_ready_d    = 1'b1;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        err_sync_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm) state_d = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                if (accept && s_sof) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = gray;
                    cnt_d     = WIDTH_ADDR'(1);
                    state_d   = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = gray;
                    // A stray start-of-frame restarts the frame rather than finishing it.
                    if (s_sof && cnt_q != '0) begin
                        err_sync_d = 1'b1;
                        wr_addr_d  = '0;
                        cnt_d      = WIDTH_ADDR'(1);
                    end else begin
                        wr_addr_d = cnt_q;
                        if (cnt_q == LAST_ADDR) begin
                            frame_done_d = 1'b1;
                            cnt_d        = '0;
                            state_d      = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + WIDTH_ADDR'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            s_ready_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_sync_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            s_ready_q    <= s_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_sync_q   <= err_sync_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign err_sync   = err_sync_q;

endmodule

// File: tb/tb_frame_capture_writer.sv
// Directed + randomized bench for frame_capture_writer, checked cycle by cycle
// against a frame-position reference model.
module tb_frame_capture_writer;

    localparam int NPIX = 200 * 200;

    logic        pixel_clk = 1'b0;
    logic        rst_n     = 1'b0;
    logic        arm       = 1'b0;
    logic        s_valid   = 1'b0;
    logic        s_sof     = 1'b0;
    logic [11:0] s_rgb     = '0;
    logic        s_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [3:0]  wr_data;
    logic        busy;
    logic        frame_done;
    logic        err_sync;

    int vectors     = 0;
    int miscompares = 0;

    // reference model: where we are in the snapshot, expressed as frame position
    bit m_ready;
    bit m_armed;
    bit m_inframe;
    int m_pos;
    int e_we, e_addr, e_data, e_fd, e_err;

    int n_writes, n_done, n_err;

    frame_capture_writer #(
        .WIDTH_ADDR (16),
        .WIDTH_COLOR(4),
        .WIDTH_IMG  (200),
        .HEIGHT_IMG (200)
    ) dut (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .arm       (arm),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_sof     (s_sof),
        .s_rgb     (s_rgb),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .frame_done(frame_done),
        .err_sync  (err_sync)
    );

    always #5 pixel_clk = ~pixel_clk;

    function automatic int gray_of(input logic [11:0] rgb);
        int r, g, b;
        r = int'(rgb[11:8]);
        g = int'(rgb[7:4]);
        b = int'(rgb[3:0]);
        return (5 * r + 9 * g + 2 * b) / 16;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ready = 0; m_armed = 0; m_inframe = 0; m_pos = 0;
        e_we = 0; e_addr = 0; e_data = 0; e_fd = 0; e_err = 0;
    endtask

    task automatic model_write(input int addr);
        e_we = 1; e_addr = addr; e_data = gray_of(s_rgb);
    endtask

    task automatic model_cycle();
        bit acc;
        acc = s_valid && m_ready;
        e_we = 0; e_fd = 0; e_err = 0;
        if (m_inframe) begin
            if (acc) begin
                if (s_sof) begin
                    e_err = 1; model_write(0); m_pos = 1;
                end else begin
                    model_write(m_pos);
                    if (m_pos == NPIX - 1) begin
                        e_fd = 1; m_inframe = 0; m_pos = 0;
                    end else m_pos++;
                end
            end
        end else if (m_armed) begin
            if (acc && s_sof) begin
                model_write(0); m_pos = 1; m_armed = 0; m_inframe = 1;
            end
        end else if (arm) begin
            m_armed = 1;
        end
        m_ready = 1;
    endtask

    task automatic step();
        model_cycle();
        @(posedge pixel_clk);
        #1;
        chk("s_ready", int'(s_ready), int'(m_ready));
        chk("wr_en", int'(wr_en), e_we);
        chk("wr_addr", int'(wr_addr), e_addr);
        chk("wr_data", int'(wr_data), e_data);
        chk("busy", int'(busy), int'(m_armed || m_inframe));
        chk("frame_done", int'(frame_done), e_fd);
        chk("err_sync", int'(err_sync), e_err);
        n_writes += int'(wr_en);
        n_done   += int'(frame_done);
        n_err    += int'(err_sync);
    endtask

    task automatic pix(input bit valid, input bit sof, input logic [11:0] rgb);
        s_valid = valid; s_sof = sof; s_rgb = rgb;
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, int'(s_ready), 0);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_addr"}, int'(wr_addr), 0);
        chk({tag, "_data"}, int'(wr_data), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(frame_done), 0);
        chk({tag, "_err"}, int'(err_sync), 0);
    endtask

    initial begin
        model_reset();
        // reset state, then release away from the clock edge
        #12;
        chk_all_zero("reset");
        @(posedge pixel_clk); #1;
        rst_n = 1'b1;
        step();

        // frame 1: arm once, stray pixels are dropped, then a full white frame
        arm = 1'b1; step(); arm = 1'b0;
        n_writes = 0; n_done = 0;
        for (int i = 0; i < 5; i++) pix(1'b1, 1'b0, 12'h123);
        chk("no_write_before_sof", n_writes, 0);
        pix(1'b1, 1'b1, 12'hFFF);
        chk("sof_addr0", int'(wr_addr), 0);
        for (int i = 1; i < NPIX; i++) pix(1'b1, 1'b0, 12'hFFF);
        chk("f1_last_addr", int'(wr_addr), NPIX - 1);
        chk("f1_last_data", int'(wr_data), 15);
        chk("f1_done_pulse", int'(frame_done), 1);
        pix(1'b1, 1'b0, 12'hFFF);
        chk("f1_writes", n_writes, NPIX);
        chk("f1_done_count", n_done, 1);
        chk("f1_busy_after", int'(busy), 0);

        // frame 2: arm held high, restart at position 1234, gray vectors, random gaps
        arm = 1'b1;
        pix(1'b0, 1'b0, 12'h000);
        n_writes = 0; n_done = 0; n_err = 0;
        pix(1'b1, 1'b1, 12'($urandom));
        for (int i = 1; i < 1234; i++) pix(1'b1, 1'b0, 12'($urandom));
        pix(1'b1, 1'b1, 12'hF00);
        chk("restart_err", int'(err_sync), 1);
        chk("restart_addr", int'(wr_addr), 0);
        chk("gray_red", int'(wr_data), 4);
        pix(1'b1, 1'b0, 12'h0F0);
        chk("restart_next_addr", int'(wr_addr), 1);
        chk("gray_green", int'(wr_data), 8);
        pix(1'b1, 1'b0, 12'h00F);
        chk("gray_blue", int'(wr_data), 1);
        pix(1'b1, 1'b0, 12'h888);
        chk("gray_mid", int'(wr_data), 8);
        begin
            int sent;
            sent = 4;
            while (sent < NPIX) begin
                if ($urandom_range(0, 9) != 0) begin
                    pix(1'b1, 1'b0, 12'($urandom));
                    sent++;
                end else begin
                    pix(1'b0, 1'($urandom), 12'($urandom));
                end
            end
        end
        chk("f2_done_count", n_done, 1);
        chk("f2_err_count", n_err, 1);
        chk("f2_writes", n_writes, 1234 + NPIX);

        // arm still high: one IDLE cycle then re-armed; reset mid-capture
        pix(1'b0, 1'b0, 12'h000);
        pix(1'b0, 1'b0, 12'h000);
        arm = 1'b0;
        pix(1'b1, 1'b1, 12'hABC);
        for (int i = 1; i < 200; i++) pix(1'b1, 1'b0, 12'($urandom));
        chk("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all_zero("midreset");
        @(posedge pixel_clk); #1;
        rst_n = 1'b1;
        n_writes = 0;
        pix(1'b0, 1'b0, 12'h000);
        pix(1'b1, 1'b1, 12'hFFF);
        for (int i = 1; i < 300; i++) pix(1'b1, 1'b0, 12'($urandom));
        chk("unarmed_writes", n_writes, 0);
        chk("unarmed_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
